// File: rtl/i2c_wb_arbiter.sv
// rtl/i2c_wb_arbiter.sv - two-master round-robin Wishbone arbiter for the i2c bridge and a host master
// Optional slave-stall watchdog enabled by defining I2C_WB_ARB_TIMEOUT_EN.
module i2c_wb_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic [1:0]          m_cyc_i,
  input  logic [1:0]          m_stb_i,
  input  logic [1:0]          m_we_i,
  input  logic [2*AW-1:0]     m_addr_i,
  input  logic [2*DW-1:0]     m_data_i,
  input  logic [2*DW/8-1:0]   m_sel_i,
  output logic [DW-1:0]       m_data_o,
  output logic [1:0]          m_ack_o,
  output logic [1:0]          m_err_o,
  output logic [1:0]          m_rty_o,
  output logic [1:0]          gnt_o,
  output logic                s_cyc_o,
  output logic                s_stb_o,
  output logic                s_we_o,
  output logic [AW-1:0]       s_addr_o,
  output logic [DW-1:0]       s_data_o,
  output logic [DW/8-1:0]     s_sel_o,
  input  logic [DW-1:0]       s_data_i,
  input  logic                s_ack_i,
  input  logic                s_err_i,
  input  logic                s_rty_i
);

  localparam int SW = DW / 8;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

  state_e state_q, state_d;
  logic   last_q, last_d;
  logic   active;
  logic   own;
  logic   stb_raw;
  logic   wd_hit;

  assign active  = (state_q != IDLE);
  assign own     = (state_q == OWN1);
  assign stb_raw = active & m_stb_i[own];
  assign gnt_o   = {state_q == OWN1, state_q == OWN0};

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // On a tie in IDLE the master that did not own the bus last wins.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        case (m_cyc_i)
          2'b01:   state_d = OWN0;
          2'b10:   state_d = OWN1;
          2'b11:   state_d = last_q ? OWN0 : OWN1;
          default: state_d = IDLE;
        endcase
      end
      OWN0: begin
        if (!m_cyc_i[0]) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end
      end
      OWN1: begin
        if (!m_cyc_i[1]) begin
          state_d = IDLE;
          last_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_addr_o = '0;
    s_data_o = '0;
    s_sel_o  = '0;
    m_data_o = '0;
    m_ack_o  = 2'b00;
    m_err_o  = 2'b00;
    m_rty_o  = 2'b00;
    if (active) begin
      s_cyc_o  = m_cyc_i[own];
      s_stb_o  = stb_raw & ~wd_hit;
      s_we_o   = m_we_i[own];
      s_addr_o = own ? m_addr_i[2*AW-1:AW] : m_addr_i[AW-1:0];
      s_data_o = own ? m_data_i[2*DW-1:DW] : m_data_i[DW-1:0];
      s_sel_o  = own ? m_sel_i[2*SW-1:SW]  : m_sel_i[SW-1:0];
      m_data_o = s_data_i;
      m_ack_o[own] = s_ack_i;
      m_err_o[own] = s_err_i | wd_hit;
      m_rty_o[own] = s_rty_i;
    end
  end

`ifdef I2C_WB_ARB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

  logic [7:0] wd_q, wd_d;

  assign wd_hit = active && (wd_q == TIMEOUT_W);

  always_comb begin
    wd_d = wd_q + 8'd1;
    if (!stb_raw || s_ack_i || s_err_i || s_rty_i || wd_hit) begin
      wd_d = 8'd0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      wd_q <= 8'd0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  // Never true: without the watchdog the arbiter waits on the slave indefinitely.
  assign wd_hit = (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_i2c_wb_arbiter.sv
// tb/tb_i2c_wb_arbiter.sv - directed self-checking bench for i2c_wb_arbiter
module tb_i2c_wb_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        m_cyc, m_stb, m_we;
  logic [2*AW-1:0]   m_addr;
  logic [2*DW-1:0]   m_wdata;
  logic [2*DW/8-1:0] m_sel;
  logic [DW-1:0]     m_rdata;
  logic [1:0]        m_ack, m_err, m_rty, gnt;
  logic              s_cyc, s_stb, s_we;
  logic [AW-1:0]     s_addr;
  logic [DW-1:0]     s_wdata;
  logic [DW/8-1:0]   s_sel;
  logic [DW-1:0]     s_rdata;
  logic              s_ack, s_err, s_rty;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  i2c_wb_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .m_cyc_i  (m_cyc),
    .m_stb_i  (m_stb),
    .m_we_i   (m_we),
    .m_addr_i (m_addr),
    .m_data_i (m_wdata),
    .m_sel_i  (m_sel),
    .m_data_o (m_rdata),
    .m_ack_o  (m_ack),
    .m_err_o  (m_err),
    .m_rty_o  (m_rty),
    .gnt_o    (gnt),
    .s_cyc_o  (s_cyc),
    .s_stb_o  (s_stb),
    .s_we_o   (s_we),
    .s_addr_o (s_addr),
    .s_data_o (s_wdata),
    .s_sel_o  (s_sel),
    .s_data_i (s_rdata),
    .s_ack_i  (s_ack),
    .s_err_i  (s_err),
    .s_rty_i  (s_rty)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m_cyc = 2'b00; m_stb = 2'b00; m_we = 2'b00;
    s_ack = 1'b0;  s_err = 1'b0;  s_rty = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    int errs;
    rst_n   = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_sel   = '0;
    s_rdata = '0;
    idle_inputs();
    #2;
    check("reset_gnt", gnt, 2'b00);
    check("reset_scyc", {s_cyc, s_stb, s_we}, 3'b000);
    check("reset_resp", {m_ack, m_err, m_rty}, 6'b0);
    step();
    rst_n = 1'b1;
    step();

    // Master 0 single write, slave acks two cycles after grant
    m_cyc = 2'b01; m_stb = 2'b01; m_we = 2'b01;
    m_addr[31:0] = 32'h10; m_wdata[31:0] = 32'hA5A5A5A5; m_sel[3:0] = 4'hF;
    #1;
    check("w0_pre_gnt", gnt, 2'b00);
    step();
    check("w0_gnt", gnt, 2'b01);
    check("w0_ctrl", {s_cyc, s_stb, s_we}, 3'b111);
    check("w0_addr", s_addr, 32'h10);
    check("w0_data", s_wdata, 32'hA5A5A5A5);
    check("w0_sel", s_sel, 4'hF);
    check("w0_noack_yet", m_ack, 2'b00);
    step();
    step();
    s_ack = 1'b1;
    #1;
    check("w0_ack", m_ack, 2'b01);
    step();
    s_ack = 1'b0;
    idle_inputs();
    #1;
    check("w0_ack_one_cycle", m_ack, 2'b00);
    step();
    check("w0_release", gnt, 2'b00);

    // Contention: alternation with a dead cycle between owners
    do_reset();
    m_addr = {32'h0000_0200, 32'h0000_0100};
    m_cyc = 2'b11; m_stb = 2'b11;
    step();
    check("tie_first_m0", gnt, 2'b01);
    check("tie_addr_m0", s_addr, 32'h100);
    m_cyc = 2'b10; m_stb = 2'b10;
    step();
    check("tie_dead1", gnt, 2'b00);
    check("tie_dead1_scyc", s_cyc, 1'b0);
    m_cyc = 2'b11; m_stb = 2'b11;
    step();
    check("tie_then_m1", gnt, 2'b10);
    check("tie_addr_m1", s_addr, 32'h200);
    s_ack = 1'b1;
    #1;
    check("tie_ack_m1_only", m_ack, 2'b10);
    s_ack = 1'b0;
    m_cyc = 2'b01; m_stb = 2'b01;
    step();
    check("tie_dead2", gnt, 2'b00);
    m_cyc = 2'b11; m_stb = 2'b11;
    step();
    check("tie_back_m0", gnt, 2'b01);
    idle_inputs();
    step();

    // Master 1 read
    m_cyc = 2'b10; m_stb = 2'b10; m_we = 2'b00;
    m_addr[63:32] = 32'h20;
    step();
    check("r1_gnt", gnt, 2'b10);
    check("r1_addr", s_addr, 32'h20);
    check("r1_we", s_we, 1'b0);
    s_rdata = 32'hDEADBEEF; s_ack = 1'b1;
    #1;
    check("r1_ack", m_ack, 2'b10);
    check("r1_data", m_rdata, 32'hDEADBEEF);
    step();
    idle_inputs();
    s_rdata = '0;
    step();

    // Retry to master 0 keeps the grant
    m_cyc = 2'b01; m_stb = 2'b01;
    step();
    s_rty = 1'b1;
    #1;
    check("rty_resp", {m_rty, m_ack}, 4'b0100);
    step();
    s_rty = 1'b0;
    #1;
    check("rty_one_cycle", m_rty, 2'b00);
    step();
    check("rty_gnt_kept", gnt, 2'b01);
    idle_inputs();
    step();

    // Stalled slave
    m_cyc = 2'b01; m_stb = 2'b01;
    step();
    errs = 0;
`ifdef I2C_WB_ARB_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      if (m_err !== 2'b00 || s_stb !== 1'b1) errs++;
      step();
    end
    check("wd_quiet_8", errs, 0);
    check("wd_err", m_err, 2'b01);
    check("wd_stb_low", s_stb, 1'b0);
    step();
    check("wd_err_one_cycle", m_err, 2'b00);
    check("wd_gnt_kept", gnt, 2'b01);
`else
    for (int i = 0; i < 1000; i++) begin
      if (m_err !== 2'b00 || s_stb !== 1'b1) errs++;
      step();
    end
    check("nowd_no_err", errs, 0);
    check("nowd_gnt_kept", gnt, 2'b01);
`endif
    idle_inputs();
    step();

    // Asynchronous reset during a master 1 strobe
    m_cyc = 2'b10; m_stb = 2'b10; m_we = 2'b10;
    m_addr[63:32] = 32'h44;
    step();
    check("rst_pre_gnt", gnt, 2'b10);
    s_ack = 1'b1; s_rdata = 32'h1234_5678;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_gnt", gnt, 2'b00);
    check("rst_ctrl", {s_cyc, s_stb, s_we}, 3'b000);
    check("rst_addr", s_addr, 32'h0);
    check("rst_resp", {m_ack, m_err, m_rty}, 6'b0);
    check("rst_rdata", m_rdata, 32'h0);
    s_ack = 1'b0; s_rdata = '0;
    m_cyc = 2'b11; m_stb = 2'b11; m_we = 2'b00;
    step();
    rst_n = 1'b1;
    step();
    check("rst_tie_m0", gnt, 2'b01);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/i2c_wb_arbiter.md
# i2c_wb_arbiter

Two-master round-robin Wishbone arbiter sharing one Wishbone slave port between the `i2c_to_wb_top` bridge (master 0) and a second host master (master 1). It sits between the bridge's `wb_*` bus and the register/memory slave. It holds grant for the whole `cyc` of the owning master. An optional watchdog terminates stalled slave cycles with an error.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width (byte selects `DW/8`)
- `TIMEOUT`, 255, slave-stall limit in cycles (1..255; used only with the watchdog)
- `wb_clk_i` in 1: single clock
- `wb_rst_i` in 1: **asynchronous, active-low reset**
- `m_cyc_i` in 2: per-master cycle request, bit n = master n
- `m_stb_i` in 2: per-master strobe
- `m_we_i` in 2: per-master write enable
- `m_addr_i` in 2*AW: `{m1,m0}` addresses
- `m_data_i` in 2*DW: `{m1,m0}` write data
- `m_sel_i` in 2*DW/8: `{m1,m0}` byte selects
- `m_data_o` out DW: read data, shared (= `s_data_i`)
- `m_ack_o` out 2: ack, routed to owner only
- `m_err_o` out 2: error, routed to owner only (also the timeout error)
- `m_rty_o` out 2: retry, routed to owner only
- `gnt_o` out 2: one-hot registered grant, 00 when idle
- `s_cyc_o`, `s_stb_o`, `s_we_o` out 1: slave control from owner
- `s_addr_o` out AW, `s_data_o` out DW, `s_sel_o` out DW/8: slave address/data/select from owner
- `s_data_i` in DW; `s_ack_i`, `s_err_i`, `s_rty_i` in 1: slave response

## Operation
- FSM states: IDLE, OWN0, OWN1. Register `last` records the most recent owner; reset value 1, so master 0 wins the first tie.
- IDLE:
  - exactly one `m_cyc_i` bit set → go to that OWNn.
  - both set → go to OWN of the master ≠ `last`.
  - none set → stay.
- OWNn: `s_*` outputs are muxed combinationally from master n. Slave responses go to bit n only; the other master sees 0 on ack/err/rty. When `m_cyc_i[n]`=0, go to IDLE and set `last`=n.
- A master that drops and re-raises `cyc` while the other master is requesting loses the next tie. This guarantees alternation under contention.
- In IDLE: `s_cyc_o`=`s_stb_o`=`s_we_o`=0, `s_addr_o`/`s_data_o`/`s_sel_o`=0, `m_ack_o`/`m_err_o`/`m_rty_o`=0.
- No transaction reordering or buffering. Each strobe passes straight through.
- Reset: all outputs 0, state IDLE, `last`=1, watchdog counter 0. Asserting reset mid-cycle aborts the transfer with no ack/err issued.

## Timing
- Grant latency: `cyc` seen in IDLE at edge k → `gnt_o` and `s_cyc_o` valid after edge k (1 cycle).
- Release: owner `cyc`=0 sampled at edge k → IDLE after k. The next grant takes effect no earlier than after edge k+1, so there is at least one dead cycle between owners.
- Master→slave request path and slave→master response path are combinational (0 added latency) once granted.
- A simultaneous `cyc` drop by the owner and rise by the other master: the drop is handled first, then the other master is granted one cycle later.

## Configuration
- `I2C_WB_ARB_TIMEOUT_EN` defined:
  - an 8-bit counter increments each cycle `s_stb_o`=1 while `s_ack_i`, `s_err_i` and `s_rty_i` are all 0.
  - it clears on any termination, in IDLE, or when the owner drops `stb`.
  - when it reaches `TIMEOUT`, the arbiter asserts `m_err_o[owner]` for exactly one cycle, forces `s_stb_o`=0 in that cycle, and clears the counter. The grant is kept until the owner drops `cyc`.
- Undefined: no counter exists, and the arbiter waits indefinitely for the slave.

## Test plan
- Master 0 only, write addr 0x10 data 0xA5A5A5A5, sel 0xF, slave acks after 2 cycles → `gnt_o`=01 one cycle after `cyc`. Slave sees the exact values; `m_ack_o`=01 for 1 cycle; `m_ack_o[1]` stays 0.
- Both masters raise `cyc` in the same cycle after reset → master 0 granted first. After it releases, one dead cycle, then master 1 granted. Repeat → master 0 next.
- Master 1 reads 0x20, slave returns 0xDEADBEEF with ack → `m_data_o`=0xDEADBEEF while `m_ack_o`=10.
- With `I2C_WB_ARB_TIMEOUT_EN`, `TIMEOUT`=8, slave never responds → `m_err_o[owner]`=1 exactly after 8 strobe cycles, `s_stb_o`=0 in that cycle. Without the macro, no error after 1000 cycles.
- Slave returns `s_rty_i` to master 0 → `m_rty_o`=01 for 1 cycle, no ack, grant retained while `cyc` is high.
- `wb_rst_i` driven low mid-transfer (OWN1, strobe active) → all outputs 0 asynchronously. After release, a tie grants master 0.
